i2c_txn_scheduler: RTL and testbench

Sequences and arbitrates I2C register transactions from two requesters onto the single bit-level I2C master FSM that drives the board's `sda`/`scl` pins.
- Port 0 is the power-up codec/config loader; port 1 is the user/debug read path.
- Grants one request at a time, round-robin, and launches it on the master with a one-cycle start pulse.
- On NACK it retries up to a bounded count; it aborts the transaction if the master hangs.
- Exports a 4-bit state code for the seven-segment debug display.

---
 rtl/i2c_txn_scheduler_pkg.sv | 26 ++
 rtl/i2c_txn_scheduler_if.sv | 32 +++
 rtl/i2c_txn_scheduler_rr_arb2.sv | 18 +
 rtl/i2c_txn_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_txn_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C transaction scheduler: the FSM state codes
// (also exported on the seven-segment debug display), the response error
// codes and the 7-bit device address width.
// -----------------------------------------------------------------------------
package i2c_pkg;

    localparam int DEV_W = 7;

    // Codes 6..15 are unused; the FSM treats them as illegal and returns to IDLE.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_GRANT   = 4'd1,
        ST_ISSUE   = 4'd2,
        ST_WAIT    = 4'd3,
        ST_RETRY   = 4'd4,
        ST_RESPOND = 4'd5
    } state_e;

    // Error field layout is {timeout, nack}.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/i2c_txn_scheduler_if.sv
// -----------------------------------------------------------------------------
// i2c_txn_scheduler_if
// Command/completion link between the transaction scheduler and the bit-level
// I2C master FSM.
//   m_start              one-cycle launch pulse (scheduler -> master)
//   m_rw/m_dev/m_reg/m_wdata  latched command, stable from m_start to response
//   m_done               one-cycle completion pulse (master -> scheduler)
//   m_nack, m_rdata      qualified by m_done
// Modports: master = scheduler side (issues commands), slave = bit engine.
// -----------------------------------------------------------------------------
interface i2c_txn_scheduler_if;

    logic                      m_start;
    logic                      m_rw;
    logic [i2c_pkg::DEV_W-1:0] m_dev;
    logic [7:0]                m_reg;
    logic [7:0]                m_wdata;
    logic                      m_done;
    logic                      m_nack;
    logic [7:0]                m_rdata;

    modport master (
        output m_start, m_rw, m_dev, m_reg, m_wdata,
        input  m_done, m_nack, m_rdata
    );

    modport slave (
        input  m_start, m_rw, m_dev, m_reg, m_wdata,
        output m_done, m_nack, m_rdata
    );

endinterface

// File: rtl/i2c_txn_scheduler_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter, purely combinational.
//   req[1:0]    request vector
//   last_grant  index of the port granted most recently
//   gnt[1:0]    one-hot grant (all zero when nothing requests)
// The port other than last_grant wins a tie; a lone requester always wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (last_grant  | ~req[1]);
    assign gnt[1] = req[1] & (~last_grant | ~req[0]);

endmodule

// File: rtl/i2c_txn_scheduler.sv
// -----------------------------------------------------------------------------
// i2c_txn_scheduler
// Arbitrates register transactions from two requesters (port 0: power-up
// config loader, port 1: user/debug path) onto one bit-level I2C master.
// One transaction is in flight at a time; NACKs are retried up to MAX_RETRY
// extra attempts and a master that never completes is aborted after TIMEOUT
// cycles in WAIT.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   req_valid/req_ready   per-port request handshake (accept = valid & ready)
//   req_rw/dev/reg/wdata  per-port command fields, port i in slice i
//   rsp_valid             one-cycle completion pulse to the owning port
//   rsp_rdata, rsp_err    read data and {timeout, nack}, valid with rsp_valid
//   m_if                  command link to the bit-level master
//   state_info            current state code for the debug display
// -----------------------------------------------------------------------------
module i2c_txn_scheduler
    import i2c_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 1_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_rw,
    input  logic [2*DEV_W-1:0]         req_dev,
    input  logic [15:0]                req_reg,
    input  logic [15:0]                req_wdata,
    output logic [1:0]                 rsp_valid,
    output logic [7:0]                 rsp_rdata,
    output logic [1:0]                 rsp_err,
    i2c_txn_scheduler_if.master        m_if,
    output logic [3:0]                 state_info
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int CW = ($clog2(TIMEOUT) < 20) ? 20 : $clog2(TIMEOUT);

    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);
    localparam logic [CW-1:0] TERM_CNT    = CW'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [RW-1:0]      retry_cnt_q, retry_cnt_d;
    logic [CW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               rw_q, rw_d;
    logic [DEV_W-1:0]   dev_q, dev_d;
    logic [7:0]         reg_q, reg_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [1:0]         err_q, err_d;

    logic [1:0]         arb_gnt;
    logic               m_start;
    logic               retry_ok;
    logic               tmo_hit;

    rr_arb2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt)
    );

    assign retry_ok = (retry_cnt_q < MAX_RETRY_C);
    assign tmo_hit  = (tmo_cnt_q == TERM_CNT);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|req_valid) state_d = ST_GRANT;
            ST_GRANT:   state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_WAIT;
            ST_WAIT: begin
                // m_done takes priority over the timeout terminal count.
                if (m_if.m_done) begin
                    state_d = (m_if.m_nack && retry_ok) ? ST_RETRY : ST_RESPOND;
                end else if (tmo_hit) begin
                    state_d = ST_RESPOND;
                end
            end
            ST_RETRY:   state_d = ST_ISSUE;
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        req_ready = 2'b00;
        m_start   = 1'b0;
        rsp_valid = 2'b00;
        rsp_rdata = 8'h00;
        rsp_err   = ERR_NONE;
        case (state_q)
            // The state is already IDLE while reset is held; gating keeps a
            // pending request from looking accepted during reset.
            ST_IDLE:    if (reset) req_ready = arb_gnt;
            ST_ISSUE:   m_start = 1'b1;
            ST_RESPOND: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    assign state_info   = state_q;
    assign m_if.m_start = m_start;
    assign m_if.m_rw    = rw_q;
    assign m_if.m_dev   = dev_q;
    assign m_if.m_reg   = reg_q;
    assign m_if.m_wdata = wdata_q;

    // ---------------------------------------------------------------- datapath next values
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        retry_cnt_d  = retry_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        rw_d         = rw_q;
        dev_d        = dev_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                // Command fields are captured on the accept edge so the
                // requester may drop req_valid immediately afterwards.
                if (|req_valid) begin
                    owner_d = arb_gnt[1];
                    if (arb_gnt[1]) begin
                        rw_d    = req_rw[1];
                        dev_d   = req_dev[2*DEV_W-1:DEV_W];
                        reg_d   = req_reg[15:8];
                        wdata_d = req_wdata[15:8];
                    end else begin
                        rw_d    = req_rw[0];
                        dev_d   = req_dev[DEV_W-1:0];
                        reg_d   = req_reg[7:0];
                        wdata_d = req_wdata[7:0];
                    end
                end
            end
            ST_GRANT: begin
                retry_cnt_d  = '0;
                last_grant_d = owner_q;
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
            end
            ST_WAIT: begin
                if (m_if.m_done) begin
                    if (!m_if.m_nack) begin
                        rdata_d = rw_q ? m_if.m_rdata : 8'h00;
                        err_d   = ERR_NONE;
                    end else if (retry_ok) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                    end else begin
                        rdata_d = 8'h00;
                        err_d   = ERR_NACK;
                    end
                end else if (tmo_hit) begin
                    rdata_d = 8'h00;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            retry_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
            rw_q         <= 1'b0;
            dev_q        <= '0;
            reg_q        <= 8'h00;
            wdata_q      <= 8'h00;
            rdata_q      <= 8'h00;
            err_q        <= ERR_NONE;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            retry_cnt_q  <= retry_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rw_q         <= rw_d;
            dev_q        <= dev_d;
            reg_q        <= reg_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_i2c_txn_scheduler
// Directed bench for i2c_txn_scheduler with MAX_RETRY=3, TIMEOUT=100. A small
// behavioural master answers each m_start after a programmable delay with a
// programmable number of NACKs first.
// -----------------------------------------------------------------------------
module tb_i2c_txn_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_rw = 2'b00;
    logic [13:0] req_dev = 14'h0;
    logic [15:0] req_reg = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_err;
    logic [3:0]  state_info;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    i2c_txn_scheduler_if mif ();

    i2c_txn_scheduler #(
        .MAX_RETRY (3),
        .TIMEOUT   (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_dev    (req_dev),
        .req_reg    (req_reg),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .m_if       (mif),
        .state_info (state_info)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Protocol monitor: ready bits never both high and only seen in IDLE.
    int both_hi = 0;
    int rdy_bad = 0;
    always @(negedge clk) begin
        if (req_ready === 2'b11) both_hi <= both_hi + 1;
        if (req_ready !== 2'b00 && state_info !== 4'd0) rdy_bad <= rdy_bad + 1;
    end

    // Behavioural bit-level master.
    int         slv_delay = 0;
    int         slv_nacks = 0;
    logic [7:0] slv_rdata = 8'h00;
    int         start_cnt = 0;
    int         start_cyc[$];
    int         done_cyc[$];

    initial begin
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt = 0;
        mif.m_done = 1'b0;
        mif.m_nack = 1'b0;
        mif.m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mif.m_done = 1'b0;
            mif.m_nack = 1'b0;
            mif.m_rdata = 8'h00;
            if (!reset) begin
                busy = 1'b0;
            end else if (busy) begin
                if (cnt == 0) begin
                    busy = 1'b0;
                    mif.m_done = 1'b1;
                    if (slv_nacks > 0) begin
                        mif.m_nack = 1'b1;
                        mif.m_rdata = 8'hEE;
                        slv_nacks--;
                    end else begin
                        mif.m_rdata = slv_rdata;
                    end
                    done_cyc.push_back(cyc);
                end else begin
                    cnt--;
                end
            end else if (mif.m_start === 1'b1) begin
                busy = 1'b1;
                cnt = slv_delay;
                start_cnt++;
                start_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Drive a request on port p and wait for its accept. Returns the IDLE
    // cycle index in which req_ready was seen; returns one cycle later (GRANT).
    task automatic start_req(input int p, input bit rw, input logic [6:0] dev,
                             input logic [7:0] rg, input logic [7:0] wd, output int acc);
        int n;
        @(negedge clk);
        req_rw[p] = rw;
        req_dev[7*p +: 7] = dev;
        req_reg[8*p +: 8] = rg;
        req_wdata[8*p +: 8] = wd;
        req_valid[p] = 1'b1;
        #1;
        n = 0;
        while (req_ready[p] !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL accept_wait: port %0d ready=%b after %0d cycles, want accept", p, req_ready, n);
        end
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(output logic [1:0] rv, output logic [7:0] rd,
                            output logic [1:0] er, output int rc);
        int n;
        rv = 2'b00;
        rd = 8'h00;
        er = 2'b00;
        rc = -1;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00) begin
                rv = rsp_valid;
                rd = rsp_rdata;
                er = rsp_err;
                rc = cyc;
                break;
            end
            n++;
        end
        if (rc < 0) begin
            total++;
            bad++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        slv_delay = 2;
        slv_nacks = 0;
        slv_rdata = 8'h3C;
        req_rw = 2'b10;
        req_dev = {7'h20, 7'h10};
        req_reg = {8'h02, 8'h01};
        req_wdata = {8'h00, 8'hA5};
        req_valid = 2'b11;
        @(negedge clk);
        #1;
        total++;
        if (state_info !== 4'd0) begin
            bad++; $display("FAIL reset_state: got %0d want 0", state_info);
        end
        total++;
        if (req_ready !== 2'b00) begin
            bad++; $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        total++;
        if ({mif.m_start, mif.m_rw, mif.m_dev, mif.m_reg, mif.m_wdata} !== 25'h0) begin
            bad++; $display("FAIL reset_mcmd: got %h want 0",
                            {mif.m_start, mif.m_rw, mif.m_dev, mif.m_reg, mif.m_wdata});
        end
        total++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== 12'h0) begin
            bad++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_rdata, rsp_err});
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_simultaneous();
        logic [1:0] rv, er, exp_rv;
        logic [7:0] rd, exp_rd;
        int rc;
        for (int i = 0; i < 4; i++) begin
            exp_rv = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_rd = (i % 2 == 0) ? 8'h00 : 8'h3C;
            wait_rsp(rv, rd, er, rc);
            if (i == 3) req_valid = 2'b00;
            total++;
            if (rv !== exp_rv) begin
                bad++; $display("FAIL rr_order[%0d]: got %b want %b", i, rv, exp_rv);
            end
            total++;
            if ({rd, er} !== {exp_rd, 2'b00}) begin
                bad++; $display("FAIL rr_data[%0d]: got rdata=%h err=%b want rdata=%h err=00",
                                i, rd, er, exp_rd);
            end
        end
    endtask

    task automatic test_single_read();
        logic [1:0] rv, er;
        logic [7:0] rd;
        int a, rc;
        slv_delay = 40;
        slv_nacks = 0;
        slv_rdata = 8'hC3;
        start_req(1, 1'b1, 7'h1A, 8'h07, 8'h00, a);
        total++;
        if (state_info !== 4'd1) begin
            bad++; $display("FAIL single_grant: state got %0d want 1", state_info);
        end
        @(posedge clk);
        #1;
        total++;
        if (mif.m_start !== 1'b1 || state_info !== 4'd2) begin
            bad++; $display("FAIL single_mstart: m_start=%b state=%0d want 1/2", mif.m_start, state_info);
        end
        total++;
        if ({mif.m_rw, mif.m_dev, mif.m_reg} !== {1'b1, 7'h1A, 8'h07}) begin
            bad++; $display("FAIL single_cmd: rw=%b dev=%h reg=%h want 1/1a/07", mif.m_rw, mif.m_dev, mif.m_reg);
        end
        @(posedge clk);
        #1;
        total++;
        if (mif.m_start !== 1'b0 || state_info !== 4'd3) begin
            bad++; $display("FAIL single_pulse: m_start=%b state=%0d want 0/3", mif.m_start, state_info);
        end
        wait_rsp(rv, rd, er, rc);
        total++;
        if (rv !== 2'b10 || rd !== 8'hC3 || er !== 2'b00) begin
            bad++; $display("FAIL single_rsp: valid=%b rdata=%h err=%b want 10/c3/00", rv, rd, er);
        end
        total++;
        if (rc != a + 44) begin
            bad++; $display("FAIL single_latency: rsp cycle %0d want %0d", rc, a + 44);
        end
        total++;
        if (mif.m_dev !== 7'h1A || mif.m_reg !== 8'h07) begin
            bad++; $display("FAIL single_stable: dev=%h reg=%h want 1a/07", mif.m_dev, mif.m_reg);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 2'b00 || state_info !== 4'd0) begin
            bad++; $display("FAIL single_after: valid=%b state=%0d want 00/0", rsp_valid, state_info);
        end
    endtask

    task automatic test_nack_retry();
        logic [1:0] rv, er;
        logic [7:0] rd;
        int a, rc;
        slv_delay = 5;
        slv_nacks = 2;
        slv_rdata = 8'h9E;
        start_cnt = 0;
        start_cyc.delete();
        done_cyc.delete();
        start_req(1, 1'b1, 7'h33, 8'h44, 8'h00, a);
        wait_rsp(rv, rd, er, rc);
        total++;
        if (start_cnt != 3) begin
            bad++; $display("FAIL retry_starts: got %0d want 3", start_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (!(start_cyc.size() > i + 1 && done_cyc.size() > i &&
                  start_cyc[i+1] - done_cyc[i] >= 2)) begin
                bad++; $display("FAIL retry_gap[%0d]: restart not >=2 cycles after m_done (starts=%0d dones=%0d)",
                                i, start_cyc.size(), done_cyc.size());
            end
        end
        total++;
        if (rv !== 2'b10 || rd !== 8'h9E || er !== 2'b00) begin
            bad++; $display("FAIL retry_rsp: valid=%b rdata=%h err=%b want 10/9e/00", rv, rd, er);
        end
        total++;
        if (rc != a + 25) begin
            bad++; $display("FAIL retry_latency: rsp cycle %0d want %0d", rc, a + 25);
        end
    endtask

    task automatic test_persistent_nack();
        logic [1:0] rv, er;
        logic [7:0] rd;
        int a, rc;
        slv_delay = 3;
        slv_nacks = 100;
        slv_rdata = 8'h5A;
        start_cnt = 0;
        start_req(0, 1'b1, 7'h50, 8'h60, 8'h00, a);
        wait_rsp(rv, rd, er, rc);
        slv_nacks = 0;
        total++;
        if (start_cnt != 4) begin
            bad++; $display("FAIL pnack_starts: got %0d want 4", start_cnt);
        end
        total++;
        if (rv !== 2'b01 || rd !== 8'h00 || er !== 2'b01) begin
            bad++; $display("FAIL pnack_rsp: valid=%b rdata=%h err=%b want 01/00/01", rv, rd, er);
        end
        total++;
        if (rc != a + 25) begin
            bad++; $display("FAIL pnack_latency: rsp cycle %0d want %0d", rc, a + 25);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] rv, er;
        logic [7:0] rd;
        int a, rc;
        // The master answers one cycle after the response, i.e. in IDLE.
        slv_delay = 101;
        slv_rdata = 8'h66;
        start_cnt = 0;
        start_req(0, 1'b1, 7'h0C, 8'h0D, 8'h00, a);
        wait_rsp(rv, rd, er, rc);
        total++;
        if (rv !== 2'b01 || rd !== 8'h00 || er !== 2'b10) begin
            bad++; $display("FAIL tmo_rsp: valid=%b rdata=%h err=%b want 01/00/10", rv, rd, er);
        end
        total++;
        if (rc != a + 103) begin
            bad++; $display("FAIL tmo_latency: rsp cycle %0d want %0d (100 after WAIT entry)", rc, a + 103);
        end
        repeat (3) @(negedge clk);
        total++;
        if (state_info !== 4'd0 || rsp_valid !== 2'b00 || start_cnt != 1) begin
            bad++; $display("FAIL tmo_late_done: state=%0d valid=%b starts=%0d want 0/00/1",
                            state_info, rsp_valid, start_cnt);
        end
    endtask

    task automatic test_timeout_terminal();
        logic [1:0] rv, er;
        logic [7:0] rd;
        int a, rc;
        slv_delay = 99;
        slv_rdata = 8'h77;
        start_req(0, 1'b1, 7'h0E, 8'h0F, 8'h00, a);
        wait_rsp(rv, rd, er, rc);
        total++;
        if (rv !== 2'b01 || rd !== 8'h77 || er !== 2'b00) begin
            bad++; $display("FAIL tmo_term_rsp: valid=%b rdata=%h err=%b want 01/77/00", rv, rd, er);
        end
        total++;
        if (rc != a + 103) begin
            bad++; $display("FAIL tmo_term_latency: rsp cycle %0d want %0d", rc, a + 103);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [1:0] rv, er;
        logic [7:0] rd;
        int a, rc;
        slv_delay = 60;
        slv_nacks = 0;
        start_req(0, 1'b0, 7'h11, 8'h22, 8'h33, a);
        repeat (10) @(negedge clk);
        total++;
        if (state_info !== 4'd3) begin
            bad++; $display("FAIL rstw_pre: state got %0d want 3", state_info);
        end
        req_rw = 2'b10;
        req_dev[6:0] = 7'h2B;
        req_reg[7:0] = 8'h3C;
        req_wdata[7:0] = 8'h4D;
        req_valid = 2'b11;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (state_info !== 4'd0 || req_ready !== 2'b00) begin
            bad++; $display("FAIL rstw_state: state=%0d ready=%b want 0/00", state_info, req_ready);
        end
        total++;
        if ({mif.m_start, mif.m_rw, mif.m_dev, mif.m_reg, mif.m_wdata} !== 25'h0) begin
            bad++; $display("FAIL rstw_mcmd: got %h want 0",
                            {mif.m_start, mif.m_rw, mif.m_dev, mif.m_reg, mif.m_wdata});
        end
        total++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== 12'h0) begin
            bad++; $display("FAIL rstw_rsp: got %h want 0", {rsp_valid, rsp_rdata, rsp_err});
        end
        slv_delay = 4;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        wait_rsp(rv, rd, er, rc);
        req_valid = 2'b00;
        total++;
        if (rv !== 2'b01 || rd !== 8'h00 || er !== 2'b00) begin
            bad++; $display("FAIL rstw_fresh: valid=%b rdata=%h err=%b want 01/00/00", rv, rd, er);
        end
        total++;
        if ({mif.m_rw, mif.m_dev, mif.m_reg, mif.m_wdata} !== {1'b0, 7'h2B, 8'h3C, 8'h4D}) begin
            bad++; $display("FAIL rstw_cmd: rw=%b dev=%h reg=%h wdata=%h want 0/2b/3c/4d",
                            mif.m_rw, mif.m_dev, mif.m_reg, mif.m_wdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_protocol();
        total++;
        if (both_hi != 0) begin
            bad++; $display("FAIL ready_onehot: both bits high in %0d cycles, want 0", both_hi);
        end
        total++;
        if (rdy_bad != 0) begin
            bad++; $display("FAIL ready_idle_only: ready outside IDLE in %0d cycles, want 0", rdy_bad);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single_read();
        test_nack_retry();
        test_persistent_nack();
        test_timeout();
        test_timeout_terminal();
        test_reset_mid_wait();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
